// File: rtl/ladybird_execute_stage_if.sv
// Operand/result handshake bundle for ladybird_execute_stage.
// slave: the execute stage. master: whatever drives operands and consumes results.
interface ladybird_execute_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            IN_VALID;
   logic            IN_READY;
   logic [2:0]      IN_OPERATION;
   logic            IN_ALTERNATE;
   logic [XLEN-1:0] IN_SRC1;
   logic [XLEN-1:0] IN_SRC2;
   logic [4:0]      IN_RS1;
   logic [4:0]      IN_RS2;
   logic [4:0]      IN_RD;
   logic            OUT_VALID;
   logic            OUT_READY;
   logic [XLEN-1:0] OUT_RESULT;
   logic [4:0]      OUT_RD;
   logic            OUT_WE;

   modport slave (
      input  IN_VALID, IN_OPERATION, IN_ALTERNATE, IN_SRC1, IN_SRC2,
             IN_RS1, IN_RS2, IN_RD, OUT_READY,
      output IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_WE
   );

   modport master (
      output IN_VALID, IN_OPERATION, IN_ALTERNATE, IN_SRC1, IN_SRC2,
             IN_RS1, IN_RS2, IN_RD, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_WE
   );
endinterface

// File: rtl/ladybird_execute_stage.sv
// Two-register integer execute stage: operand register A feeds the ALU,
// result register B drives the output bundle. Full-throughput valid/ready.
// Optional feature: define LADYBIRD_EXEC_FORWARD_EN to forward B's result
// into A's operands when B.rd matches A.rs1/A.rs2 (rd 0 never forwards).
module ladybird_execute_stage #(
   parameter int unsigned XLEN = 32
) (
   input logic                   CLK,
   input logic                   RESET_N,
   ladybird_execute_stage_if.slave bus
);
   localparam int unsigned RW  = 5;
   localparam int unsigned SHW = 5;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SLL  = 3'b001;
   localparam logic [2:0] OP_SLT  = 3'b010;
   localparam logic [2:0] OP_SLTU = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SR   = 3'b101;
   localparam logic [2:0] OP_OR   = 3'b110;
   localparam logic [2:0] OP_AND  = 3'b111;

   typedef struct packed {
      logic [2:0]      op;
      logic            alt;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
`ifdef LADYBIRD_EXEC_FORWARD_EN
      logic [RW-1:0]   rs1;
      logic [RW-1:0]   rs2;
`endif
      logic [RW-1:0]   rd;
   } a_bundle_t;

   logic            a_valid;
   a_bundle_t       a_q;
   logic            b_valid;
   logic            b_we;
   logic [XLEN-1:0] b_result;
   logic [RW-1:0]   b_rd;

   logic            a_to_b;
   logic            in_ready;
   logic            in_fire;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] result;
   logic            lt_signed;
   logic            lt_unsigned;

   // Handshake control: A drains into B whenever B is empty or being emptied.
   always_comb begin
      a_to_b   = a_valid && (!b_valid || bus.OUT_READY);
      in_ready = !a_valid || a_to_b;
      in_fire  = bus.IN_VALID && in_ready;
   end

   assign bus.IN_READY   = in_ready;
   assign bus.OUT_VALID  = b_valid;
   assign bus.OUT_RESULT = b_result;
   assign bus.OUT_RD     = b_rd;
   assign bus.OUT_WE     = b_we;

`ifndef LADYBIRD_EXEC_FORWARD_EN
   logic unused_rs;
   assign unused_rs = ^{bus.IN_RS1, bus.IN_RS2};
`endif

   // Operand select: latched operands, optionally overridden by B's result.
   always_comb begin
      op1 = a_q.src1;
      op2 = a_q.src2;
`ifdef LADYBIRD_EXEC_FORWARD_EN
      if (b_valid && (b_rd != '0) && (b_rd == a_q.rs1)) op1 = b_result;
      if (b_valid && (b_rd != '0) && (b_rd == a_q.rs2)) op2 = b_result;
`endif
   end

   // ALU: add/sub, shifts (amount from op2 low bits), logic ops.
   always_comb begin
      alu_out = '0;
      case (a_q.op)
         OP_ADD:  alu_out = a_q.alt ? (op1 + ~op2 + XLEN'(1)) : (op1 + op2);
         OP_SLL:  alu_out = op1 << op2[SHW-1:0];
         OP_XOR:  alu_out = op1 ^ op2;
         OP_SR:   alu_out = a_q.alt ? XLEN'($signed(op1) >>> op2[SHW-1:0])
                                    : (op1 >> op2[SHW-1:0]);
         OP_OR:   alu_out = op1 | op2;
         OP_AND:  alu_out = op1 & op2;
         default: alu_out = '0;
      endcase
   end

   // Set-less-than results replace the ALU output for slt/sltu.
   always_comb begin
      lt_signed   = $signed(op1) < $signed(op2);
      lt_unsigned = op1 < op2;
      result      = alu_out;
      if (a_q.op == OP_SLT)  result = XLEN'(lt_signed);
      if (a_q.op == OP_SLTU) result = XLEN'(lt_unsigned);
   end

   // Stage A: capture the operand bundle on input handshake.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         a_valid <= 1'b0;
         a_q     <= '0;
      end else begin
         if (in_fire) begin
            a_valid  <= 1'b1;
            a_q.op   <= bus.IN_OPERATION;
            a_q.alt  <= bus.IN_ALTERNATE;
            a_q.src1 <= bus.IN_SRC1;
            a_q.src2 <= bus.IN_SRC2;
`ifdef LADYBIRD_EXEC_FORWARD_EN
            a_q.rs1  <= bus.IN_RS1;
            a_q.rs2  <= bus.IN_RS2;
`endif
            a_q.rd   <= bus.IN_RD;
         end else if (a_to_b) begin
            a_valid <= 1'b0;
         end
      end
   end

   // Stage B: register the result; hold while the consumer stalls.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         b_valid  <= 1'b0;
         b_we     <= 1'b0;
         b_result <= '0;
         b_rd     <= '0;
      end else begin
         if (a_to_b) begin
            b_valid  <= 1'b1;
            b_we     <= (a_q.rd != '0);
            b_result <= result;
            b_rd     <= a_q.rd;
         end else if (bus.OUT_READY) begin
            b_valid <= 1'b0;
            b_we    <= 1'b0;
         end
      end
   end
endmodule

// File: doc/ladybird_execute_stage.md
LADYBIRD_EXECUTE_STAGE -- requirements
Module: ladybird_execute_stage

Interface
REQ-001 SHALL take parameter XLEN, default 32 (from ladybird_config): datapath width; only 32 is supported.
REQ-002 SHALL have port CLK, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port RESET_N, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port IN_VALID, input, 1: upstream operand bundle valid.
REQ-005 SHALL have port IN_READY, output, 1: stage accepts bundle this cycle.
REQ-006 SHALL have port IN_OPERATION, input, 3: funct3-coded op (000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and).
REQ-007 SHALL have port IN_ALTERNATE, input, 1: sub/sra select.
REQ-008 SHALL have ports IN_SRC1 and IN_SRC2, input, XLEN each: operands.
REQ-009 SHALL have ports IN_RS1 and IN_RS2, input, 5 each: source register indices, used only for forwarding.
REQ-010 SHALL have port IN_RD, input, 5: destination register index.
REQ-011 SHALL have port OUT_VALID, output, 1: result bundle valid.
REQ-012 SHALL have port OUT_READY, input, 1: downstream accepts.
REQ-013 SHALL have port OUT_RESULT, output, XLEN: result.
REQ-014 SHALL have port OUT_RD, output, 5: destination index.
REQ-015 SHALL have port OUT_WE, output, 1: write enable, 1 when OUT_VALID and OUT_RD != 0.

Function
REQ-016 SHALL contain two pipeline registers: operand stage A, latched on IN_VALID&&IN_READY, and result stage B.
REQ-017 SHALL evaluate stage A through the existing ladybird_alu combinationally and load stage B on A->B transfer; latency from input handshake to OUT_VALID is 2 cycles.
REQ-018 SHALL complete a transfer only on VALID&&READY; OUT_VALID, OUT_RESULT, OUT_RD and OUT_WE SHALL hold stable while OUT_VALID&&!OUT_READY.
REQ-019 SHALL perform A->B when A is valid and (B is empty or OUT_READY); IN_READY = !A_valid || A->B transfer this cycle, giving full throughput of one bundle per cycle.
REQ-020 SHALL handle simultaneous input accept, A->B and output accept in one cycle with no loss or duplication.
REQ-021 SHALL compute slt (signed) and sltu (unsigned) itself, as zero-extended 1-bit results, and substitute them for the ALU output for ops 010 and 011.
REQ-022 SHALL implement sub as SRC1 + ~SRC2 + 1 when IN_ALTERNATE=1 and op=000, wrapping mod 2^XLEN.
REQ-023 SHALL honour ALTERNATE for op 101 only (sra); ALTERNATE on other ops has no effect except op 000.
REQ-024 SHALL use shift amounts from SRC2[4:0] only.
REQ-025 SHALL have no combinational path from IN_* to OUT_*.

Reset
REQ-026 SHALL on RESET_N=0 immediately clear A_valid and B_valid, driving OUT_VALID=0, OUT_WE=0, OUT_RESULT=0, OUT_RD=0; IN_READY=1 after reset release.
REQ-027 SHALL discard in-flight bundles when reset is asserted mid-operation; none reappear after release.

Configuration
REQ-028 SHALL with macro LADYBIRD_EXEC_FORWARD_EN defined replace A's SRC1 (SRC2) at ALU input with B's result when B valid, B.rd != 0 and B.rd == A.rs1 (A.rs2), evaluated each cycle A waits.
REQ-029 SHALL without LADYBIRD_EXEC_FORWARD_EN ignore IN_RS1/IN_RS2 and use latched operands unmodified.

Verification
REQ-030 SHALL be verified with: add 0x7FFFFFFF+1, rd=3 -> OUT_RESULT=0x80000000, OUT_WE=1, 2 cycles after accept.
REQ-031 SHALL be verified with: sra 0x80000000 by 4 (ALTERNATE=1) -> 0xF8000000; srl same -> 0x08000000.
REQ-032 SHALL be verified with: slt 0xFFFFFFFF,1 -> 1; sltu same -> 0; sub 0-1 -> 0xFFFFFFFF.
REQ-033 SHALL be verified with: OUT_READY=0 for 5 cycles, 3 bundles offered -> IN_READY drops after 2 accepted, OUT held stable, all 3 delivered in order once OUT_READY=1.
REQ-034 SHALL be verified with: FORWARD_EN, B rd=5 result 10, A rs1=5 SRC1=0 add 1 -> 11; rd=0 in B -> 1; without macro -> 1.
REQ-035 SHALL be verified with: RESET_N low while both stages full -> OUT_VALID=0 same cycle, no output after release until new input accepted.
